micro_mult_host: RTL and testbench
==================================

// Module: micro_mult_host
// PURPOSE
// - Host-side initiator for the tt_um_njp_micro multiplier pin interface; the other end of the pins a bench drives.
// - Takes 8x8 operand requests over a valid/ready port and sequences them onto ui_in/uio_in.
// - Waits for done, reads the 16-bit product back over uo_out in two byte phases and returns it on a response port.
// - Used in FPGA/in-system test harnesses in place of the cocotb driver.
// PARAMETERS
// - TIMEOUT   default 255  max cycles in WAIT for done before aborting; >=1
// - CNT_W     default 8    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
// - clk        in   1   single clock, rising edge
// - rst        in   1   asynchronous, active-high reset
// - req_valid  in   1   operand request valid
// - req_ready  out  1   high only in IDLE
// - req_a      in   8   multiplicand
// - req_b      in   8   multiplier
// - rsp_valid  out  1   response valid; held until accepted
// - rsp_ready  in   1   response accept
// - rsp_prod   out  16  product {hi,lo}; 16'h0000 on timeout
// - rsp_tmo    out  1   1 = done not seen within TIMEOUT cycles
// - pin_ui     out  8   to DUT ui_in: operand byte
// - pin_uio    out  8   to DUT uio_in: [1:0] cmd (00 nop, 01 load A, 10 load B, 11 start), [2] byte select (0 lo, 1 hi), [7:3] 0
// - pin_uo     in   8   from DUT uo_out: product byte selected by pin_uio[2]
// - pin_done   in   1   from DUT uio_out[7]: product ready, level
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; req_ready=1, rsp_valid=0, rsp_prod=0, rsp_tmo=0, pin_ui=0, pin_uio=0, counter=0.
// - All outputs registered; pin_ui/pin_uio change only on clk edges.
// - IDLE: req_ready=1, pin_uio=0. On req_valid&&req_ready capture a,b -> LOAD_A.
// - LOAD_A (1 cyc): pin_ui=a, cmd=01 -> LOAD_B.
// - LOAD_B (1 cyc): pin_ui=b, cmd=10 -> START.
// - START (1 cyc): pin_ui=0, cmd=11; clear counter -> WAIT.
// - WAIT: cmd=00, sel=0. pin_done sampled each cycle; done=1 -> READ_LO. Else counter++;
//   counter reaches TIMEOUT with done still 0 -> RESP with rsp_tmo=1, rsp_prod=0.
//   done high on the cycle counter would hit TIMEOUT: done wins (no timeout).
// - READ_LO (1 cyc): sel=0 held from WAIT; capture pin_uo into prod[7:0]; drive sel=1 -> READ_HI.
// - READ_HI (1 cyc): capture pin_uo into prod[15:8] (sel=1 stable one full cycle); sel->0 -> RESP.
// - RESP: rsp_valid=1, rsp_prod/rsp_tmo stable; on rsp_ready -> IDLE same edge, rsp_valid=0 next cycle.
//   No new request accepted until RESP handshake completes (one transaction in flight).
// - Latency req accept -> rsp_valid: 3 (load/start) + W (WAIT cycles incl. done cycle) + 2 (reads) + 1.
// - pin_done glitches in non-WAIT states are ignored. req_* changing while not ready is ignored.
// - rst mid-transaction: immediate abort to IDLE, pins to 0, no response emitted.
// - Product is unsigned 16 bit; module does no arithmetic, only byte assembly.
// TESTING
// - a=8'd12,b=8'd13, done after 4 cyc, DUT bytes 9C/00 -> rsp_prod=16'h009C, rsp_tmo=0, pin_uio seq 01,10,11,00.
// - a=b=8'hFF, bytes 01/FE -> rsp_prod=16'hFE01; check sel=1 only in READ_HI.
// - done never asserted, TIMEOUT=255 -> rsp_valid after exactly 255 WAIT cycles, rsp_tmo=1, rsp_prod=0.
// - done rises on the 255th WAIT cycle -> normal read, rsp_tmo=0.
// - rsp_ready low 10 cyc -> rsp_* held stable, req_ready=0 throughout, new req_valid ignored.
// - rst pulsed in WAIT -> all outputs 0, req_ready=1 next cycle, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/micro_mult_host.sv
// micro_mult_host
//
// Host-side initiator for the tt_um_njp_micro 8x8 multiplier pin interface.
// An operand pair is accepted on the request port and driven onto the
// multiplier pins as: load A, load B, start. The host then waits for the
// multiplier's done level and reads the 16-bit product back one byte at a
// time. The product, or a timeout indication, is returned on the response
// port. Only one transaction is in flight at a time.
//
// Parameters
//   TIMEOUT   maximum number of WAIT cycles without done before giving up (>= 1)
//   CNT_W     width of the WAIT cycle counter, 2**CNT_W must exceed TIMEOUT
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  operand request valid
//   req_ready  high only while idle
//   req_a      multiplicand
//   req_b      multiplier
//   rsp_valid  response valid, held until rsp_ready
//   rsp_ready  response accept
//   rsp_prod   product {hi,lo}, zero on timeout
//   rsp_tmo    done was not seen within TIMEOUT cycles
//   pin_ui     operand byte to the multiplier ui_in
//   pin_uio    to uio_in: [1:0] cmd (00 nop, 01 load A, 10 load B, 11 start),
//              [2] product byte select (0 lo, 1 hi), [7:3] zero
//   pin_uo     product byte from the multiplier uo_out
//   pin_done   product ready level from the multiplier uio_out[7]

module micro_mult_host #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_prod,
    output logic        rsp_tmo,
    output logic [7:0]  pin_ui,
    output logic [7:0]  pin_uio,
    input  logic [7:0]  pin_uo,
    input  logic        pin_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        READ_LO,
        READ_HI,
        RESP
    } state_t;

    localparam logic [7:0] UIO_NOP    = 8'h00;
    localparam logic [7:0] UIO_LOAD_A = 8'h01;
    localparam logic [7:0] UIO_LOAD_B = 8'h02;
    localparam logic [7:0] UIO_START  = 8'h03;
    localparam logic [7:0] UIO_SEL_HI = 8'h04;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_t           state_q;
    logic [7:0]       b_q;
    logic [7:0]       lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [15:0]      rsp_prod_q;
    logic             rsp_tmo_q;
    logic [7:0]       pin_ui_q;
    logic [7:0]       pin_uio_q;

    // Count of WAIT cycles that have gone by without done, including this one.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    // Transaction sequencer. Every output is a register loaded on the edge
    // that enters the state it belongs to, so the pins the multiplier sees
    // only ever change on clk edges. pin_done is looked at only in WAIT,
    // which keeps stale or glitching done levels in other states harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            b_q         <= 8'h00;
            lo_q        <= 8'h00;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= 16'h0000;
            rsp_tmo_q   <= 1'b0;
            pin_ui_q    <= 8'h00;
            pin_uio_q   <= UIO_NOP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= LOAD_A;
                        req_ready_q <= 1'b0;
                        b_q         <= req_b;
                        pin_ui_q    <= req_a;
                        pin_uio_q   <= UIO_LOAD_A;
                    end
                end
                LOAD_A: begin
                    state_q   <= LOAD_B;
                    pin_ui_q  <= b_q;
                    pin_uio_q <= UIO_LOAD_B;
                end
                LOAD_B: begin
                    state_q   <= START;
                    pin_ui_q  <= 8'h00;
                    pin_uio_q <= UIO_START;
                end
                START: begin
                    state_q   <= WAIT;
                    cnt_q     <= '0;
                    pin_uio_q <= UIO_NOP;
                end
                WAIT: begin
                    // done is checked before the limit so that done arriving
                    // on the final allowed cycle still yields a normal read.
                    if (pin_done) begin
                        state_q <= READ_LO;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_LIMIT) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_prod_q  <= 16'h0000;
                            rsp_tmo_q   <= 1'b1;
                        end
                    end
                end
                READ_LO: begin
                    // Select has been low since WAIT, so the low byte is settled.
                    state_q   <= READ_HI;
                    lo_q      <= pin_uo;
                    pin_uio_q <= UIO_SEL_HI;
                end
                READ_HI: begin
                    state_q     <= RESP;
                    pin_uio_q   <= UIO_NOP;
                    rsp_valid_q <= 1'b1;
                    rsp_prod_q  <= {pin_uo, lo_q};
                    rsp_tmo_q   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    pin_ui_q    <= 8'h00;
                    pin_uio_q   <= UIO_NOP;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign pin_ui    = pin_ui_q;
    assign pin_uio   = pin_uio_q;

endmodule

// File: tb/tb_micro_mult_host.sv
// tb_micro_mult_host
//
// Drives operand requests into micro_mult_host and plays the far-end
// multiplier on the pin side: it latches the operand bytes on the load
// commands, computes the product on start and raises done a chosen number
// of cycles later (or never). Each transaction's expected response, latency
// and pin command sequence are worked out from the operands and the done
// delay alone.

module tb_micro_mult_host;

    localparam int TIMEOUT = 255;
    localparam int CNT_W   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = 8'h00;
    logic [7:0]  req_b = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_prod;
    logic        rsp_tmo;
    logic [7:0]  pin_ui;
    logic [7:0]  pin_uio;
    logic [7:0]  pin_uo;
    logic        pin_done = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    // Cycles after start at which the multiplier raises done; 0 means never.
    int doneLatency = 0;

    logic [7:0]  mdlA = 8'h00;
    logic [7:0]  mdlB = 8'h00;
    logic [15:0] mdlProd = 16'h0000;
    logic        mdlBusy = 1'b0;
    int          mdlCnt = 0;

    micro_mult_host #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_prod (rsp_prod),
        .rsp_tmo  (rsp_tmo),
        .pin_ui   (pin_ui),
        .pin_uio  (pin_uio),
        .pin_uo   (pin_uo),
        .pin_done (pin_done)
    );

    always #5 clk = ~clk;

    // Far-end multiplier. It reacts on the falling edge so it always sees
    // settled host pins and its done level is stable at the next rising edge.
    // done stays high after a product is ready until the next start command.
    always @(negedge clk) begin
        if (rst) begin
            mdlBusy  = 1'b0;
            pin_done = 1'b0;
        end else begin
            case (pin_uio[1:0])
                2'b01: mdlA = pin_ui;
                2'b10: mdlB = pin_ui;
                2'b11: begin
                    mdlProd  = 16'(mdlA) * 16'(mdlB);
                    pin_done = 1'b0;
                    mdlBusy  = 1'b1;
                    mdlCnt   = 0;
                end
                default: begin
                    if (mdlBusy) begin
                        mdlCnt++;
                        if (doneLatency != 0 && mdlCnt == doneLatency) begin
                            pin_done = 1'b1;
                            mdlBusy  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign pin_uo = pin_uio[2] ? mdlProd[15:8] : mdlProd[7:0];

    // Hard stop in case something wedges the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One full request/response transaction. lat is the multiplier done delay
    // in WAIT cycles (0 = never), hold the number of extra cycles the response
    // is left waiting before it is accepted.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input int lat, input int hold);
        logic        expTmo;
        int          waitCycles;
        int          expLatency;
        logic [15:0] expProd;
        logic [7:0]  expUio[$];
        logic [7:0]  expUi[$];
        logic [7:0]  obsUio[$];
        logic [7:0]  obsUi[$];
        int          n;
        int          readyBad;
        bit          seen;

        expTmo     = (lat == 0) || (lat > TIMEOUT);
        waitCycles = expTmo ? TIMEOUT : lat;
        expProd    = expTmo ? 16'h0000 : 16'(a) * 16'(b);
        expLatency = expTmo ? 3 + waitCycles + 1 : 3 + waitCycles + 2 + 1;

        expUio = {8'h01, 8'h02, 8'h03};
        expUi  = {a, b, 8'h00};
        for (int i = 0; i < waitCycles; i++) begin
            expUio.push_back(8'h00);
            expUi.push_back(8'h00);
        end
        if (!expTmo) begin
            expUio.push_back(8'h00);
            expUio.push_back(8'h04);
            expUi.push_back(8'h00);
            expUi.push_back(8'h00);
        end
        expUio.push_back(8'h00);
        expUi.push_back(8'h00);

        doneLatency = lat;
        @(negedge clk);
        checkOutput("req_ready before request", req_ready, 1'b1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;

        n = 0;
        readyBad = 0;
        seen = 1'b0;
        while (!seen && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
            // Keep a live, changing request on the port; it must be ignored.
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            obsUio.push_back(pin_uio);
            obsUi.push_back(pin_ui);
            if (rsp_valid) seen = 1'b1;
            else if (req_ready) readyBad++;
        end
        req_valid = 1'b0;

        checkOutput("response latency", n, expLatency);
        checkOutput("req_ready low while busy", readyBad, 0);
        checkOutput("pin_uio cycle count", obsUio.size(), expUio.size());
        for (int i = 0; i < obsUio.size() && i < expUio.size(); i++) begin
            checkOutput($sformatf("pin_uio cycle %0d", i + 1), obsUio[i], expUio[i]);
            checkOutput($sformatf("pin_ui cycle %0d", i + 1), obsUi[i], expUi[i]);
        end
        checkOutput("rsp_prod", rsp_prod, expProd);
        checkOutput("rsp_tmo", rsp_tmo, expTmo);

        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a     = 8'($urandom);
            req_b     = 8'($urandom);
            @(negedge clk);
            checkOutput("rsp_valid held", rsp_valid, 1'b1);
            checkOutput("rsp_prod held", rsp_prod, expProd);
            checkOutput("rsp_tmo held", rsp_tmo, expTmo);
            checkOutput("req_ready low in RESP", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid after accept", rsp_valid, 1'b0);
        checkOutput("req_ready after accept", req_ready, 1'b1);
        checkOutput("pin_uio idle after accept", pin_uio, 8'h00);
    endtask

    task automatic checkResetOutputs(input string when);
        checkOutput({when, " req_ready"}, req_ready, 1'b1);
        checkOutput({when, " rsp_valid"}, rsp_valid, 1'b0);
        checkOutput({when, " rsp_prod"}, rsp_prod, 16'h0000);
        checkOutput({when, " rsp_tmo"}, rsp_tmo, 1'b0);
        checkOutput({when, " pin_ui"}, pin_ui, 8'h00);
        checkOutput({when, " pin_uio"}, pin_uio, 8'h00);
    endtask

    initial begin
        int rspSeen;

        // Power-on reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed transactions.
        applyStimulus(8'd12, 8'd13, 4, 0);
        applyStimulus(8'hFF, 8'hFF, 3, 1);
        applyStimulus(8'h5A, 8'hC3, 0, 0);
        applyStimulus(8'h37, 8'h81, TIMEOUT, 0);
        applyStimulus(8'h02, 8'h80, TIMEOUT + 1, 0);
        applyStimulus(8'hA7, 8'h3E, 5, 10);
        applyStimulus(8'h00, 8'hFF, 1, 2);

        // Reset in the middle of a WAIT: abort with no response.
        doneLatency = 50;
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 8'h21;
        req_b     = 8'h43;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("mid-transaction reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("req_ready after reset release", req_ready, 1'b1);
        rspSeen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp_valid) rspSeen++;
        end
        checkOutput("no response after abort", rspSeen, 0);
        applyStimulus(8'h21, 8'h43, 6, 0);

        // Randomised transactions.
        for (int t = 0; t < 8; t++) begin
            applyStimulus(8'($urandom), 8'($urandom),
                          int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
